// File: rtl/sqrt_arb_pkg.sv
// Shared defaults and FSM state encoding for the two-requester magnitude-engine arbiter.
package sqrt_arb_pkg;

   localparam int MAX_WIDTH_DEF      = 13;
   localparam int CADC_WIDTH_DEF     = 10;
   localparam int TIMEOUT_CYCLES_DEF = 512;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_RESP = 2'd3
   } arb_state_e;

endpackage

// File: rtl/sqrt_req_arbiter_if.sv
// Requester and engine signal bundle for sqrt_req_arbiter; slave = arbiter side, master = environment side.
interface sqrt_req_arbiter_if
   import sqrt_arb_pkg::*;
#(
   parameter int MAX_WIDTH  = MAX_WIDTH_DEF,
   parameter int CADC_WIDTH = CADC_WIDTH_DEF
);

   // Handshake: reqN is a level, sampled only while the arbiter is idle; operands must be
   // valid whenever reqN is high. ackN is a single-cycle pulse during which rsp_data/rsp_id/
   // rsp_err are valid; they then hold until the next ack. eng_enable rises once per job and
   // eng_done is honoured from the second enabled cycle on.
   logic                  req0;
   logic                  req1;
   logic [MAX_WIDTH-1:0]  x0;
   logic [MAX_WIDTH-1:0]  y0;
   logic [MAX_WIDTH-1:0]  x1;
   logic [MAX_WIDTH-1:0]  y1;
   logic [CADC_WIDTH-1:0] off0;
   logic [CADC_WIDTH-1:0] off1;
   logic                  ack0;
   logic                  ack1;
   logic [MAX_WIDTH-1:0]  rsp_data;
   logic                  rsp_id;
   logic                  rsp_err;
   logic                  eng_enable;
   logic [MAX_WIDTH-1:0]  eng_x;
   logic [MAX_WIDTH-1:0]  eng_y;
   logic [CADC_WIDTH-1:0] eng_offset;
   logic [MAX_WIDTH-1:0]  eng_fout;
   logic                  eng_done;

   modport slave (
      input  req0, req1, x0, y0, x1, y1, off0, off1, eng_fout, eng_done,
      output ack0, ack1, rsp_data, rsp_id, rsp_err, eng_enable, eng_x, eng_y, eng_offset
   );

   modport master (
      output req0, req1, x0, y0, x1, y1, off0, off1, eng_fout, eng_done,
      input  ack0, ack1, rsp_data, rsp_id, rsp_err, eng_enable, eng_x, eng_y, eng_offset
   );

endinterface

// File: rtl/sqrt_rr_pick2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the one not served last.
module sqrt_rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic gnt_valid,
   output logic gnt_id
);

   always_comb begin
      gnt_valid = req0 | req1;
      gnt_id    = 1'b0;
      if (req0 && req1) begin
         gnt_id = ~last;
      end else if (req1) begin
         gnt_id = 1'b1;
      end
   end

endmodule

// File: rtl/sqrt_req_arbiter.sv
// Arbitrates two requesters onto one magnitude engine (IDLE->ARM->RUN->RESP).
// Optional RUN watchdog enabled by defining SQRT_ARB_TIMEOUT_EN.
module sqrt_req_arbiter
   import sqrt_arb_pkg::*;
#(
   parameter int MAX_WIDTH      = MAX_WIDTH_DEF,
   parameter int CADC_WIDTH     = CADC_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic               CLK,
   input  logic               RST,
   sqrt_req_arbiter_if.slave  bus,
   output arb_state_e         dbg_state
);

   if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   arb_state_e            state_q, state_d;
   logic                  last_q, last_d;
   logic                  gnt_id_q, gnt_id_d;
   logic                  first_q, first_d;
   logic [MAX_WIDTH-1:0]  x_q, x_d;
   logic [MAX_WIDTH-1:0]  y_q, y_d;
   logic [CADC_WIDTH-1:0] off_q, off_d;
   logic [MAX_WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic                  rsp_id_q, rsp_id_d;

   logic pick_valid;
   logic pick_id;

   sqrt_rr_pick2 u_pick (
      .req0      (bus.req0),
      .req1      (bus.req1),
      .last      (last_q),
      .gnt_valid (pick_valid),
      .gnt_id    (pick_id)
   );

`ifdef SQRT_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_err_q, rsp_err_d;
   logic             timeout_hit;

   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_ARM) begin
         cnt_d = '0;
      end else if (state_q == ST_RUN) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q     <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         rsp_err_q <= rsp_err_d;
      end
   end
`else
   logic timeout_hit;
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      gnt_id_d   = gnt_id_q;
      first_d    = 1'b0;
      x_d        = x_q;
      y_d        = y_q;
      off_d      = off_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
`ifdef SQRT_ARB_TIMEOUT_EN
      rsp_err_d  = rsp_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               gnt_id_d = pick_id;
               x_d      = pick_id ? bus.x1   : bus.x0;
               y_d      = pick_id ? bus.y1   : bus.y0;
               off_d    = pick_id ? bus.off1 : bus.off0;
               state_d  = ST_ARM;
            end
         end
         ST_ARM: begin
            first_d = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            // A done seen on the first enabled cycle belongs to the previous job.
            if (!first_q && bus.eng_done) begin
               rsp_data_d = bus.eng_fout;
               rsp_id_d   = gnt_id_q;
`ifdef SQRT_ARB_TIMEOUT_EN
               rsp_err_d  = 1'b0;
`endif
               state_d    = ST_RESP;
            end else if (timeout_hit) begin
               rsp_data_d = '0;
               rsp_id_d   = gnt_id_q;
`ifdef SQRT_ARB_TIMEOUT_EN
               rsp_err_d  = 1'b1;
`endif
               state_d    = ST_RESP;
            end
         end
         ST_RESP: begin
            last_d  = gnt_id_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         last_q     <= 1'b1;
         gnt_id_q   <= 1'b0;
         first_q    <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         off_q      <= '0;
         rsp_data_q <= '0;
         rsp_id_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         gnt_id_q   <= gnt_id_d;
         first_q    <= first_d;
         x_q        <= x_d;
         y_q        <= y_d;
         off_q      <= off_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

   // Decoded straight from state so reset kills enable and ack without waiting for a clock.
   assign bus.eng_enable = (state_q == ST_RUN);
   assign bus.ack0       = (state_q == ST_RESP) && !gnt_id_q;
   assign bus.ack1       = (state_q == ST_RESP) &&  gnt_id_q;
   assign bus.eng_x      = x_q;
   assign bus.eng_y      = y_q;
   assign bus.eng_offset = off_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_id     = rsp_id_q;
`ifdef SQRT_ARB_TIMEOUT_EN
   assign bus.rsp_err    = rsp_err_q;
`else
   assign bus.rsp_err    = 1'b0;
`endif
   assign dbg_state      = state_q;

endmodule
